// File: rtl/scan_to_ascii.sv
// PS/2 Set-2 make code plus Shift state to 7-bit ASCII, zero-extended to 8 bits.
// Purely combinational table lookup followed by a single output register.
module scan_to_ascii #(
    parameter logic [7:0] UNMAPPED = 8'h00
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] outdata
);

    logic [7:0] ascii;

    always_comb begin
        // NOTE: default first so every path assigns ascii and no latch is inferred.
        ascii = UNMAPPED;
        case (code)
            // letters
            8'h1C: ascii = shift ? 8'h41 : 8'h61;
            8'h32: ascii = shift ? 8'h42 : 8'h62;
            8'h21: ascii = shift ? 8'h43 : 8'h63;
            8'h23: ascii = shift ? 8'h44 : 8'h64;
            8'h24: ascii = shift ? 8'h45 : 8'h65;
            8'h2B: ascii = shift ? 8'h46 : 8'h66;
            8'h34: ascii = shift ? 8'h47 : 8'h67;
            8'h33: ascii = shift ? 8'h48 : 8'h68;
            8'h43: ascii = shift ? 8'h49 : 8'h69;
            8'h3B: ascii = shift ? 8'h4A : 8'h6A;
            8'h42: ascii = shift ? 8'h4B : 8'h6B;
            8'h4B: ascii = shift ? 8'h4C : 8'h6C;
            8'h3A: ascii = shift ? 8'h4D : 8'h6D;
            8'h31: ascii = shift ? 8'h4E : 8'h6E;
            8'h44: ascii = shift ? 8'h4F : 8'h6F;
            8'h4D: ascii = shift ? 8'h50 : 8'h70;
            8'h15: ascii = shift ? 8'h51 : 8'h71;
            8'h2D: ascii = shift ? 8'h52 : 8'h72;
            8'h1B: ascii = shift ? 8'h53 : 8'h73;
            8'h2C: ascii = shift ? 8'h54 : 8'h74;
            8'h3C: ascii = shift ? 8'h55 : 8'h75;
            8'h2A: ascii = shift ? 8'h56 : 8'h76;
            8'h1D: ascii = shift ? 8'h57 : 8'h77;
            8'h22: ascii = shift ? 8'h58 : 8'h78;
            8'h35: ascii = shift ? 8'h59 : 8'h79;
            8'h1A: ascii = shift ? 8'h5A : 8'h7A;
            // digit row
            8'h45: ascii = shift ? 8'h29 : 8'h30;
            8'h16: ascii = shift ? 8'h21 : 8'h31;
            8'h1E: ascii = shift ? 8'h40 : 8'h32;
            8'h26: ascii = shift ? 8'h23 : 8'h33;
            8'h25: ascii = shift ? 8'h24 : 8'h34;
            8'h2E: ascii = shift ? 8'h25 : 8'h35;
            8'h36: ascii = shift ? 8'h5E : 8'h36;
            8'h3D: ascii = shift ? 8'h26 : 8'h37;
            8'h3E: ascii = shift ? 8'h2A : 8'h38;
            8'h46: ascii = shift ? 8'h28 : 8'h39;
            // punctuation
            8'h0E: ascii = shift ? 8'h7E : 8'h60;
            8'h4E: ascii = shift ? 8'h5F : 8'h2D;
            8'h55: ascii = shift ? 8'h2B : 8'h3D;
            8'h54: ascii = shift ? 8'h7B : 8'h5B;
            8'h5B: ascii = shift ? 8'h7D : 8'h5D;
            8'h5D: ascii = shift ? 8'h7C : 8'h5C;
            8'h4C: ascii = shift ? 8'h3A : 8'h3B;
            8'h52: ascii = shift ? 8'h22 : 8'h27;
            8'h41: ascii = shift ? 8'h3C : 8'h2C;
            8'h49: ascii = shift ? 8'h3E : 8'h2E;
            8'h4A: ascii = shift ? 8'h3F : 8'h2F;
            // controls, identical with or without Shift
            8'h29: ascii = 8'h20;
            8'h0D: ascii = 8'h09;
            8'h5A: ascii = 8'h0D;
            8'h66: ascii = 8'h08;
            8'h76: ascii = 8'h1B;
            8'h00: ascii = 8'h00;
            default: ascii = UNMAPPED;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for registered state avoids simulation races.
        if (clrn) outdata <= 8'h00;
        else      outdata <= ascii;
    end

endmodule

// File: tb/tb_scan_to_ascii.sv
// Directed and exhaustive checks of scan_to_ascii against an independent
// table-driven model built from per-group code lists and character tables.
module tb_scan_to_ascii;

    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] code;
    logic       shift;
    logic [7:0] outdata;

    int tests = 0;
    int fails = 0;

    scan_to_ascii dut (
        .clk    (clk),
        .clrn   (clrn),
        .code   (code),
        .shift  (shift),
        .outdata(outdata)
    );

    always #5 clk = ~clk;

    // Codes listed in alphabet / digit / character-table order.
    localparam logic [7:0] LETTER_CODES [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGIT_CODES [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    localparam logic [7:0] PUNCT_CODES [11] = '{
        8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
    localparam logic [7:0] PUNCT_PLAIN [11] = '{
        8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
    localparam logic [7:0] PUNCT_SHIFTED [11] = '{
        8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
    localparam logic [7:0] CTRL_CODES [6] = '{8'h29, 8'h0D, 8'h5A, 8'h66, 8'h76, 8'h00};
    localparam logic [7:0] CTRL_VALS  [6] = '{8'h20, 8'h09, 8'h0D, 8'h08, 8'h1B, 8'h00};

    string digit_shifted = ")!@#$%^&*(";

    function automatic logic [7:0] model(input logic [7:0] c, input logic s);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 26; i++)
            if (c == LETTER_CODES[i]) r = (s ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (c == DIGIT_CODES[i]) r = s ? 8'(digit_shifted[i]) : 8'h30 + 8'(i);
        for (int i = 0; i < 11; i++)
            if (c == PUNCT_CODES[i]) r = s ? PUNCT_SHIFTED[i] : PUNCT_PLAIN[i];
        for (int i = 0; i < 6; i++)
            if (c == CTRL_CODES[i]) r = CTRL_VALS[i];
        return r;
    endfunction

    // Apply inputs on a falling edge; return on the next falling edge, after one rising edge.
    task automatic step(input logic [7:0] c, input logic s);
        @(negedge clk);
        clrn  = 1'b0;
        code  = c;
        shift = s;
        @(negedge clk);
    endtask

    task automatic test_reset;
        step(8'h1C, 1'b0);
        @(negedge clk);
        clrn = 1'b1; code = 8'h1C; shift = 1'b0;
        @(negedge clk);
        tests++;
        if (outdata !== 8'h00) begin
            fails++; $display("FAIL reset_clear got=%h exp=00", outdata);
        end
        clrn = 1'b0;
        @(negedge clk);
        tests++;
        if (outdata !== 8'h61) begin
            fails++; $display("FAIL reset_release got=%h exp=61", outdata);
        end
    endtask

    task automatic test_letters;
        step(8'h1C, 1'b0);
        tests++; if (outdata !== 8'h61) begin fails++; $display("FAIL letter_a got=%h exp=61", outdata); end
        step(8'h1C, 1'b1);
        tests++; if (outdata !== 8'h41) begin fails++; $display("FAIL letter_A got=%h exp=41", outdata); end
        step(8'h1A, 1'b1);
        tests++; if (outdata !== 8'h5A) begin fails++; $display("FAIL letter_Z got=%h exp=5A", outdata); end
        step(8'h1A, 1'b0);
        tests++; if (outdata !== 8'h7A) begin fails++; $display("FAIL letter_z got=%h exp=7A", outdata); end
    endtask

    task automatic test_digits;
        step(8'h45, 1'b0);
        tests++; if (outdata !== 8'h30) begin fails++; $display("FAIL digit_0 got=%h exp=30", outdata); end
        step(8'h45, 1'b1);
        tests++; if (outdata !== 8'h29) begin fails++; $display("FAIL digit_rparen got=%h exp=29", outdata); end
        step(8'h16, 1'b1);
        tests++; if (outdata !== 8'h21) begin fails++; $display("FAIL digit_bang got=%h exp=21", outdata); end
        step(8'h3E, 1'b1);
        tests++; if (outdata !== 8'h2A) begin fails++; $display("FAIL digit_star got=%h exp=2A", outdata); end
    endtask

    task automatic test_punct;
        step(8'h4A, 1'b0);
        tests++; if (outdata !== 8'h2F) begin fails++; $display("FAIL punct_slash got=%h exp=2F", outdata); end
        step(8'h4A, 1'b1);
        tests++; if (outdata !== 8'h3F) begin fails++; $display("FAIL punct_question got=%h exp=3F", outdata); end
        step(8'h52, 1'b1);
        tests++; if (outdata !== 8'h22) begin fails++; $display("FAIL punct_dquote got=%h exp=22", outdata); end
        step(8'h5D, 1'b0);
        tests++; if (outdata !== 8'h5C) begin fails++; $display("FAIL punct_backslash got=%h exp=5C", outdata); end
    endtask

    task automatic test_controls;
        logic [7:0] codes [8] = '{8'h29, 8'h66, 8'h5A, 8'h0D, 8'h12, 8'hF0, 8'hE0, 8'h75};
        logic [7:0] exps  [8] = '{8'h20, 8'h08, 8'h0D, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) begin
            for (int s = 0; s < 2; s++) begin
                step(codes[i], s[0]);
                tests++;
                if (outdata !== exps[i]) begin
                    fails++;
                    $display("FAIL control code=%h shift=%0d got=%h exp=%h", codes[i], s, outdata, exps[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] codes [3] = '{8'h1C, 8'h32, 8'h21};
        logic [7:0] exps  [3] = '{8'h61, 8'h62, 8'h63};
        @(negedge clk);
        clrn = 1'b0; shift = 1'b0; code = codes[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (outdata !== exps[i]) begin
                fails++; $display("FAIL back_to_back idx=%0d got=%h exp=%h", i, outdata, exps[i]);
            end
            if (i < 2) code = codes[i + 1];
        end
    endtask

    task automatic test_sweep;
        logic [7:0] exp;
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 256; c++) begin
                step(8'(c), s[0]);
                exp = model(8'(c), s[0]);
                tests++;
                if (outdata !== exp) begin
                    fails++;
                    $display("FAIL sweep code=%h shift=%0d got=%h exp=%h", 8'(c), s, outdata, exp);
                end
            end
        end
    endtask

    initial begin
        clrn  = 1'b1;
        code  = 8'h00;
        shift = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        test_letters;
        test_digits;
        test_punct;
        test_controls;
        test_back_to_back;
        test_sweep;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
